// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - load/store request and response bundle for the data-memory responder
//
// Request channel:  req_valid/req_ready handshake carrying req_write, req_addr (byte address)
//                   and req_wdata (store data).
// Response channel: rsp_valid/rsp_ready handshake carrying rsp_rdata (load data) and rsp_err.
// master: the processor-side requester.  slave: the memory-side responder.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - latency-configurable word memory behind a valid/ready load/store port
//
// Accepts one word-aligned load or store at a time.  The access is performed LATENCY
// cycles after acceptance, and the response holds until the requester takes it.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset (memory contents are not cleared)
//   bus  - slave side of dmem_responder_if (request and response handshakes)
// Parameters:
//   DEPTH   - number of 32-bit words, power of two, >= 2
//   LATENCY - cycles from acceptance to rsp_valid, >= 1
module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(LATENCY - 1);
  localparam logic [29:0]      DEPTH_WORDS = 30'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

  stateT             state, stateNext;
  logic [CNT_W-1:0]  cnt;
  logic              outOfReset;
  logic              wrReg;
  logic [31:0]       addrReg;
  logic [31:0]       wdataReg;
  logic [31:0]       rdataReg;
  logic              errReg;
  logic              accept;
  logic              access;
  logic              commit;
  logic              addrErr;
  logic [IDX_W-1:0]  wordIdx;
  logic [31:0]       mem [DEPTH];

  // Indices at or beyond DEPTH are errors rather than aliases, so the full
  // upper address field is compared, not just the index bits.
  always_comb begin
    addrErr = (addrReg[1:0] != 2'b00) || (addrReg[31:2] >= DEPTH_WORDS);
    wordIdx = addrReg[IDX_W+1:2];
  end

  // outOfReset gates req_ready so that a request present in the cycle reset
  // is released is not taken; readiness appears after the first edge.
  always_comb begin
    stateNext     = state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    accept        = 1'b0;
    access        = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = outOfReset;
        if (bus.req_valid && outOfReset) begin
          accept    = 1'b1;
          stateNext = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          access    = 1'b1;
          stateNext = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign commit        = access && wrReg && !addrErr;
  assign bus.rsp_rdata = rdataReg;
  assign bus.rsp_err   = errReg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      outOfReset <= 1'b0;
      wrReg      <= 1'b0;
      addrReg    <= '0;
      wdataReg   <= '0;
      rdataReg   <= '0;
      errReg     <= 1'b0;
    end else begin
      state      <= stateNext;
      outOfReset <= 1'b1;
      if (accept) begin
        wrReg    <= bus.req_write;
        addrReg  <= bus.req_addr;
        wdataReg <= bus.req_wdata;
        cnt      <= CNT_LOAD;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (access) begin
        errReg   <= addrErr;
        rdataReg <= (!wrReg && !addrErr) ? mem[wordIdx] : '0;
      end
    end
  end

  // Storage has no reset; a reset during WAIT returns state to IDLE
  // immediately, so a pending store can never reach this commit.
  always_ff @(posedge clk) begin
    if (commit) begin
      mem[wordIdx] <= wdataReg;
    end
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Latency-configurable data-memory responder: the memory-side end of the processor's load/store interface, with a valid/ready handshake in place of the single-cycle combinational read path. It accepts one word-aligned read or write request at a time, performs the access after a fixed number of wait cycles, and returns read data or a write acknowledgement with an error flag. It sits between the processor's data port and word storage, and is the building block for multi-cycle and stalling memory models.

## Interface
- DEPTH, 64: number of 32-bit words stored; power of two, ≥ 2.
- LATENCY, 2: cycles from request acceptance to response valid; ≥ 1.

- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  misaligned or out-of-range access.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req_ready = 1. On an edge with req_valid && req_ready:
  - capture req_write, req_addr, and req_wdata;
  - load the wait counter with LATENCY-1;
  - go to WAIT.
- WAIT: req_ready = 0.
  - cnt ≠ 0: decrement.
  - cnt = 0: perform the access, register rsp_rdata and rsp_err, go to RESP.
- RESP: rsp_valid = 1 and req_ready = 0. On an edge with rsp_ready, go to IDLE and clear rsp_valid. req_valid is ignored outside IDLE.
- Address check:
  - err = (addr[1:0] ≠ 0) || (addr[31:2] ≥ DEPTH).
  - word index = addr[31:2] when err = 0.
- Store, err = 0: mem[index] ← wdata at the edge entering RESP; rsp_rdata = 0; rsp_err = 0.
- Load, err = 0: rsp_rdata = mem[index], sampled at the edge entering RESP; rsp_err = 0.
- Any err = 1: memory is unchanged; rsp_rdata = 0; rsp_err = 1.
- rsp_rdata and rsp_err are registered and held stable for the whole of RESP.
- Memory contents are not touched by reset; unwritten words are undefined.

## Timing
- Reset (rst low, asynchronous): state = IDLE, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, cnt = 0.
- After rst rises, req_ready = 1 from the first cycle.
- req_ready is held low while rst is low, so no request can be accepted during reset.
- Latency: if the request is accepted at edge E, rsp_valid is high after edge E+LATENCY. LATENCY = 1 gives a response in the cycle after acceptance.
- Store commit happens at edge E+LATENCY, not at acceptance.
- Throughput:
  - with rsp_ready held high, one transaction per LATENCY+2 cycles;
  - the next request is accepted no earlier than the cycle after the response handshake;
  - there is no acceptance in the response-handshake cycle.
- Backpressure: RESP holds indefinitely while rsp_ready = 0. Outputs do not change.
- Reset mid-operation:
  - in WAIT, the transaction is aborted and a pending store is never committed;
  - in RESP, the response is dropped.
  - In both cases all outputs go to their reset values immediately.
- Address wrap: none. Indices ≥ DEPTH are errors and never alias.
- A request presented in the same cycle that rst rises is not accepted (req_ready is still 0).

## Test plan
- Reset: hold rst low 2 cycles with req_valid = 1 → req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0. Release rst → req_ready = 1 next cycle, and no transaction was started.
- Store/load, LATENCY = 2, DEPTH = 64:
  - store 0xDEADBEEF to 0x10 → rsp_valid high exactly 2 cycles after acceptance, rsp_err = 0, rsp_rdata = 0;
  - load 0x10 → rsp_rdata = 0xDEADBEEF.
  - Repeat at the last word 0xFC with 0x0BADF00D.
- Backpressure: load 0x10 with rsp_ready low for 3 cycles → rsp_valid and rsp_rdata = 0xDEADBEEF held. A new req_valid during this time is not accepted (req_ready = 0). The handshake completes on the cycle rsp_ready rises.
- Errors:
  - store 0x11111111 to 0x13 → rsp_err = 1;
  - store to 0x100 → rsp_err = 1;
  - load 0x100 → rsp_err = 1, rsp_rdata = 0;
  - load 0x10 → still 0xDEADBEEF.
- Reset mid-store:
  - store 0xA5A5A5A5 to 0x20 and complete it;
  - accept a store of 0x12345678 to 0x20, then pulse rst low one cycle after acceptance (before commit);
  - after reset, load 0x20 → 0xA5A5A5A5.
- LATENCY = 1 build: back-to-back loads with rsp_ready held high → rsp_valid one cycle after each acceptance, with one IDLE cycle between transactions (period 3 cycles).
